// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the SPI-flash-to-RAMIO boot loader.
package flash_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] READ_OPCODE = 8'h03;
  localparam logic [1:0] WT_NONE     = 2'b00;
  localparam logic [1:0] WT_WORD     = 2'b11;

  localparam int         CNT_W       = 6;
  localparam logic [5:0] CMD_BITS    = 6'd32;
  localparam logic [5:0] BYTE_BITS   = 6'd8;

  // Byte address of a destination word; the add wraps naturally at 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [29:0] idx);
    return base + {idx, 2'b00};
  endfunction

endpackage

// File: rtl/flash_loader_spi_shifter.sv
// SPI mode-0 bit engine: flash_clk = clk/2, MSB-first shift out, shift in on rising clock.
// The rising half of a bit is suppressed while pause is high, so the clock parks low.
module spi_shifter
  import flash_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [31:0]      load_data,
  input  logic             run,
  input  logic             pause,
  input  logic             clr_cnt,
  input  logic             miso,
  output logic             sck,
  output logic             mosi,
  output logic [7:0]       rx_byte,
  output logic [CNT_W-1:0] bit_cnt
);

  logic             sck_r;
  logic             mosi_r;
  logic [31:0]      tx_sr_r;
  logic [7:0]       rx_sr_r;
  logic [CNT_W-1:0] bit_cnt_r;

  // Clock toggle, shift registers and per-bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_r     <= 1'b0;
      mosi_r    <= 1'b0;
      tx_sr_r   <= 32'h0000_0000;
      rx_sr_r   <= 8'h00;
      bit_cnt_r <= 6'd0;
    end else if (load) begin
      sck_r     <= 1'b0;
      mosi_r    <= load_data[31];
      tx_sr_r   <= {load_data[30:0], 1'b0};
      bit_cnt_r <= 6'd0;
    end else if (run) begin
      if (sck_r) begin
        // falling edge: present the next outgoing bit while the clock is low
        sck_r     <= 1'b0;
        mosi_r    <= tx_sr_r[31];
        tx_sr_r   <= {tx_sr_r[30:0], 1'b0};
        bit_cnt_r <= clr_cnt ? 6'd0 : bit_cnt_r;
      end else if (!pause) begin
        sck_r     <= 1'b1;
        rx_sr_r   <= {rx_sr_r[6:0], miso};
        bit_cnt_r <= bit_cnt_r + 6'd1;
      end else begin
        sck_r     <= 1'b0;
      end
    end else begin
      sck_r  <= 1'b0;
      mosi_r <= 1'b0;
    end
  end

  assign sck     = sck_r;
  assign mosi    = mosi_r;
  assign rx_byte = rx_sr_r;
  assign bit_cnt = bit_cnt_r;

endmodule

// File: rtl/flash_loader.sv
// Copies LOAD_BYTES from SPI flash (READ 0x03) into RAMIO as little-endian 32-bit words.
// Optional FLASH_LOADER_CHECKSUM_EN adds a running 32-bit sum of the written words.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter logic [23:0] FLASH_ADDR = 24'h00_0000,
  parameter logic [31:0] RAM_ADDR   = 32'h0000_0000,
  parameter int          LOAD_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        flash_clk,
  output logic        flash_mosi,
  output logic        flash_cs,
  input  logic        flash_miso,
  output logic        ramio_enable,
  output logic [1:0]  ramio_write_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic        ramio_busy
`ifdef FLASH_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  generate
    if (LOAD_BYTES <= 0 || (LOAD_BYTES % 4) != 0) begin : g_len_check
      $error("flash_loader: LOAD_BYTES must be a nonzero multiple of 4");
    end
  endgenerate

  localparam logic [29:0] LAST_WORD = 30'(LOAD_BYTES / 4 - 1);

  state_t           state_r;
  logic             busy_r;
  logic             done_r;
  logic             cs_r;
  logic             en_r;
  logic [1:0]       wt_r;
  logic [31:0]      addr_r;
  logic [31:0]      data_r;
  logic [1:0]       byte_idx_r;
  logic [29:0]      word_idx_r;

  logic             load_s;
  logic             run_s;
  logic             pause_s;
  logic             clr_s;
  logic [7:0]       rx_byte_s;
  logic [CNT_W-1:0] bit_cnt_s;

  spi_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data ({READ_OPCODE, FLASH_ADDR}),
    .run       (run_s),
    .pause     (pause_s),
    .clr_cnt   (clr_s),
    .miso      (flash_miso),
    .sck       (flash_clk),
    .mosi      (flash_mosi),
    .rx_byte   (rx_byte_s),
    .bit_cnt   (bit_cnt_s)
  );

  // Shifter control derived from the current state.
  always_comb begin
    load_s  = 1'b0;
    run_s   = 1'b0;
    pause_s = 1'b0;
    clr_s   = 1'b0;
    case (state_r)
      ST_IDLE:  load_s = start;
      ST_CMD: begin
        run_s = 1'b1;
        clr_s = (bit_cnt_s == CMD_BITS);
      end
      ST_DATA: begin
        run_s = 1'b1;
        clr_s = (bit_cnt_s == BYTE_BITS);
      end
      ST_WRITE, ST_WAIT: begin
        run_s   = 1'b1;
        pause_s = 1'b1;
      end
      default: begin
        run_s   = 1'b0;
        pause_s = 1'b0;
      end
    endcase
  end

  // Main sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cs_r       <= 1'b1;
      en_r       <= 1'b0;
      wt_r       <= WT_NONE;
      addr_r     <= 32'h0000_0000;
      data_r     <= 32'h0000_0000;
      byte_idx_r <= 2'd0;
      word_idx_r <= 30'd0;
    end else begin
      en_r <= 1'b0;
      wt_r <= WT_NONE;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_CMD;
            cs_r       <= 1'b0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            byte_idx_r <= 2'd0;
            word_idx_r <= 30'd0;
          end
        end
        ST_CMD: begin
          if (bit_cnt_s == CMD_BITS) begin
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_cnt_s == BYTE_BITS) begin
            data_r[{byte_idx_r, 3'b000} +: 8] <= rx_byte_s;
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              state_r <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (!ramio_busy) begin
            en_r    <= 1'b1;
            wt_r    <= WT_WORD;
            addr_r  <= word_addr(RAM_ADDR, word_idx_r);
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // the enable cycle itself is skipped so RAMIO has a cycle to raise busy
          if (!en_r && !ramio_busy) begin
            if (word_idx_r == LAST_WORD) begin
              state_r <= ST_DONE;
              cs_r    <= 1'b1;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              word_idx_r <= word_idx_r + 30'd1;
              state_r    <= ST_DATA;
            end
          end
        end
        ST_DONE:  state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [31:0] checksum_r;

  // Running sum of every word handed to RAMIO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_r <= 32'h0000_0000;
    end else if (state_r == ST_IDLE && start) begin
      checksum_r <= 32'h0000_0000;
    end else if (state_r == ST_WRITE && !ramio_busy) begin
      checksum_r <= checksum_r + data_r;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`endif

  assign busy             = busy_r;
  assign done             = done_r;
  assign flash_cs         = cs_r;
  assign ramio_enable     = en_r;
  assign ramio_write_type = wt_r;
  assign ramio_address    = addr_r;
  assign ramio_data_in    = data_r;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader: SPI flash model, RAMIO busy model and write scoreboard.
module tb_flash_loader;

  localparam logic [23:0] FA = 24'h10_0000;
  localparam logic [31:0] RA = 32'hFFFF_FFFC;
  localparam int          LB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flash_miso = 1'b0;
  logic        force_busy = 1'b0;
  wire         busy, done, flash_clk, flash_mosi, flash_cs, ramio_enable, ramio_busy;
  wire  [1:0]  ramio_write_type;
  wire  [31:0] ramio_address, ramio_data_in;
`ifdef FLASH_LOADER_CHECKSUM_EN
  wire  [31:0] checksum;
`endif

  int          checks = 0;
  int          errors = 0;
  int          n_enables = 0;
  int          bad_type = 0;
  int          busy_cnt = 0;
  logic [63:0] exp_q[$];

  int          cmd_bits = 0;
  int          data_bit = 0;
  logic [31:0] cmd_sr = 32'h0;
  logic [31:0] cmd_seen = 32'h0;

  flash_loader #(.FLASH_ADDR(FA), .RAM_ADDR(RA), .LOAD_BYTES(LB)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .flash_clk        (flash_clk),
    .flash_mosi       (flash_mosi),
    .flash_cs         (flash_cs),
    .flash_miso       (flash_miso),
    .ramio_enable     (ramio_enable),
    .ramio_write_type (ramio_write_type),
    .ramio_address    (ramio_address),
    .ramio_data_in    (ramio_data_in),
    .ramio_busy       (ramio_busy)
`ifdef FLASH_LOADER_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a, input int k);
    int off;
    off = int'(a - FA) + k;
    if (off >= 0 && off < LB) return 8'(17 * (off + 1));
    else return 8'hEE;
  endfunction

  // Flash model: command capture on rising flash_clk, restart on every cs fall.
  always @(posedge flash_clk or negedge flash_cs) begin
    if (flash_clk) begin
      if (cmd_bits < 32) begin
        cmd_sr = {cmd_sr[30:0], flash_mosi};
        cmd_bits++;
        if (cmd_bits == 32) cmd_seen = cmd_sr;
      end else begin
        data_bit++;
      end
    end else begin
      cmd_bits = 0;
      data_bit = 0;
      cmd_seen = 32'h0;
    end
  end

  // Flash model: drive the next data bit while flash_clk is low.
  always @(negedge flash_clk) begin
    logic [7:0] b;
    if (!flash_cs && cmd_bits >= 32) begin
      b = flash_byte(cmd_seen[23:0], data_bit / 8);
      flash_miso = b[7 - (data_bit % 8)];
    end
  end

  // RAMIO model: busy for three cycles after each enable, or while forced.
  always @(posedge clk) begin
    if (ramio_enable) busy_cnt <= 3;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign ramio_busy = force_busy | (busy_cnt != 0);

  // Scoreboard: every enable pops one expected {address, data}.
  always @(negedge clk) begin
    logic [63:0] w;
    if (ramio_enable === 1'b1) begin
      n_enables++;
      check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("wr_addr", 64'(ramio_address), 64'(w[63:32]));
        check("wr_data", 64'(ramio_data_in), 64'(w[31:0]));
      end
      check("wr_type", 64'(ramio_write_type), 64'(2'b11));
    end else if (ramio_write_type !== 2'b00) begin
      bad_type++;
    end
  end

  task automatic push_words();
    exp_q.push_back({RA, 32'h4433_2211});
    exp_q.push_back({RA + 32'd4, 32'h8877_6655});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < 2000), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, n, seen, sck_hi, en_hold;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cs", 64'(flash_cs), 64'd1);
    check("rst_sck", 64'(flash_clk), 64'd0);
    check("rst_mosi", 64'(flash_mosi), 64'd0);
    check("rst_en", 64'(ramio_enable), 64'd0);
    check("rst_type", 64'(ramio_write_type), 64'd0);
    check("rst_addr", 64'(ramio_address), 64'd0);
    check("rst_data", 64'(ramio_data_in), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic load with address wrap, ignored start mid-load and in the done cycle
    push_words();
    en0 = n_enables;
    pulse_start();
    check("a_busy", 64'(busy), 64'd1);
    check("a_cs_low", 64'(flash_cs), 64'd0);
    repeat (100) @(negedge clk);
    pulse_start();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("a_finish", 64'(n < 2000), 64'd1);
    check("a_done", 64'(done), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("a_start_at_fall_ignored", 64'(busy), 64'd0);
    check("a_done_sticky", 64'(done), 64'd1);
    check("a_cs_high", 64'(flash_cs), 64'd1);
    check("a_sck_low", 64'(flash_clk), 64'd0);
    check("a_cmd_stream", 64'(cmd_seen), 64'h0310_0000);
    check("a_enables", 64'(n_enables - en0), 64'd2);
    check("a_sb_drained", 64'(exp_q.size()), 64'd0);
`ifdef FLASH_LOADER_CHECKSUM_EN
    check("a_checksum", 64'(checksum), 64'hCCAA_8866);
`endif

    // RAMIO busy held at the first write: stream paused, no enable until release
    force_busy = 1'b1;
    push_words();
    en0 = n_enables;
    pulse_start();
    check("b_done_cleared", 64'(done), 64'd0);
    n = 0;
    while (data_bit < 32 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("b_reach_write", 64'(n < 2000), 64'd1);
    repeat (4) @(negedge clk);
    sck_hi = 0;
    en_hold = 0;
    repeat (50) begin
      @(negedge clk);
      if (flash_clk) sck_hi++;
      if (ramio_enable) en_hold++;
    end
    check("b_no_enable_held", 64'(en_hold), 64'd0);
    check("b_sck_static", 64'(sck_hi), 64'd0);
    check("b_cs_held", 64'(flash_cs), 64'd0);
    force_busy = 1'b0;
    n = n_enables;
    repeat (12) @(negedge clk);
    check("b_one_enable", 64'(n_enables - n), 64'd1);
    wait_idle("b_finish");
    check("b_enables", 64'(n_enables - en0), 64'd2);
    check("b_done", 64'(done), 64'd1);

    // Reset after the second word, then restart from word 0
    push_words();
    pulse_start();
    n = 0;
    seen = 0;
    while (seen < 2 && n < 2000) begin
      @(negedge clk);
      #1;
      if (ramio_enable) seen++;
      n++;
    end
    check("c_reach_w2", 64'(n < 2000), 64'd1);
    check("c_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("c_rst_cs", 64'(flash_cs), 64'd1);
    check("c_rst_busy", 64'(busy), 64'd0);
    check("c_rst_en", 64'(ramio_enable), 64'd0);
    check("c_rst_done", 64'(done), 64'd0);
    en0 = n_enables;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("c_no_enable_after_rst", 64'(n_enables - en0), 64'd0);
    check("c_sb_drained_pre", 64'(exp_q.size()), 64'd0);
    push_words();
    en0 = n_enables;
    pulse_start();
    wait_idle("c_finish");
    check("c_enables", 64'(n_enables - en0), 64'd2);
    check("c_cmd_stream", 64'(cmd_seen), 64'h0310_0000);
    check("c_sb_drained", 64'(exp_q.size()), 64'd0);
`ifdef FLASH_LOADER_CHECKSUM_EN
    check("c_checksum", 64'(checksum), 64'hCCAA_8866);
`endif
    check("type_idle_zero", 64'(bad_type), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
